// File: rtl/serdiv_issue_ctrl_pkg.sv
// Shared types for the serial-divider issue controller.
// Request bundle and controller state encoding.
package serdiv_issue_ctrl_pkg;

   localparam int unsigned TRANS_ID_BITS = 3;
   localparam int unsigned DIV_WIDTH     = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } issue_state_e;

   typedef struct packed {
      logic [TRANS_ID_BITS-1:0] id;
      logic [DIV_WIDTH-1:0]     op_a;
      logic [DIV_WIDTH-1:0]     op_b;
      logic [1:0]               opcode;
   } div_req_t;

endpackage

// File: rtl/serdiv_req_fifo.sv
// Small request FIFO with synchronous flush.
// A count register separates full from empty.
module serdiv_req_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter type         T     = logic
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic flush_i,
   input  logic push_i,
   input  T     data_i,
   input  logic pop_i,
   output T     data_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   T              r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_cnt;
   logic          w_push;
   logic          w_pop;

   assign full_o  = (r_cnt == CW'(DEPTH));
   assign empty_o = (r_cnt == '0);
   assign w_push  = push_i & ~full_o & ~flush_i;
   assign w_pop   = pop_i & ~empty_o & ~flush_i;
   assign data_o  = r_mem[r_rptr];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else if (flush_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= data_i;
            r_wptr        <= r_wptr + 1'b1;
         end
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         if (w_push & ~w_pop)
            r_cnt <= r_cnt + 1'b1;
         else if (w_pop & ~w_push)
            r_cnt <= r_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/serdiv_issue_ctrl.sv
// Issue/writeback controller for the serial divider: one op in flight,
// registered result slot, returned-id check and latency watchdog.
import serdiv_issue_ctrl_pkg::*;

module serdiv_issue_ctrl #(
   parameter int unsigned WIDTH      = DIV_WIDTH,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned TIMEOUT    = 80
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [TRANS_ID_BITS-1:0] req_id_i,
   input  logic [WIDTH-1:0]         req_op_a_i,
   input  logic [WIDTH-1:0]         req_op_b_i,
   input  logic [1:0]               req_opcode_i,
   output logic                     div_in_vld_o,
   input  logic                     div_in_rdy_i,
   output logic [TRANS_ID_BITS-1:0] div_id_o,
   output logic [WIDTH-1:0]         div_op_a_o,
   output logic [WIDTH-1:0]         div_op_b_o,
   output logic [1:0]               div_opcode_o,
   output logic                     div_flush_o,
   input  logic                     div_out_vld_i,
   output logic                     div_out_rdy_o,
   input  logic [TRANS_ID_BITS-1:0] div_id_i,
   input  logic [WIDTH-1:0]         div_res_i,
   output logic                     wb_valid_o,
   input  logic                     wb_ready_i,
   output logic [TRANS_ID_BITS-1:0] wb_id_o,
   output logic [WIDTH-1:0]         wb_res_o,
   output logic                     timeout_o,
   output logic                     id_err_o,
   output logic                     busy_o
);

   localparam int unsigned     TW    = $clog2(TIMEOUT);
   localparam logic [TW-1:0]   TLAST = TW'(TIMEOUT - 1);

   issue_state_e             r_state;
   logic [TW-1:0]            r_timer;
   logic [TRANS_ID_BITS-1:0] r_exp_id;
   logic [TRANS_ID_BITS-1:0] r_wb_id;
   logic [WIDTH-1:0]         r_wb_res;

   div_req_t w_req_in;
   div_req_t w_head;
   logic     w_full;
   logic     w_empty;
   logic     w_push;
   logic     w_issue_hs;
   logic     w_capture;
   logic     w_abort;

   assign w_req_in = '{id: req_id_i, op_a: req_op_a_i,
                       op_b: req_op_b_i, opcode: req_opcode_i};

   assign req_ready_o = ~w_full & ~flush_i;
   assign w_push      = req_valid_i & req_ready_o;
   assign w_issue_hs  = (r_state == ISSUE) & div_in_rdy_i & ~flush_i;
   assign w_capture   = (r_state == WAIT) & div_out_vld_i & ~flush_i;
   assign w_abort     = (r_state == WAIT) & ~div_out_vld_i
                      & (r_timer == TLAST) & ~flush_i;

   serdiv_req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (div_req_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (w_push),
      .data_i  (w_req_in),
      .pop_i   (w_issue_hs),
      .data_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   assign div_in_vld_o  = (r_state == ISSUE);
   assign div_id_o      = w_head.id;
   assign div_op_a_o    = w_head.op_a;
   assign div_op_b_o    = w_head.op_b;
   assign div_opcode_o  = w_head.opcode;
   assign div_out_rdy_o = (r_state == WAIT);
   assign div_flush_o   = flush_i | w_abort;

   assign wb_valid_o = (r_state == RESP);
   assign wb_id_o    = r_wb_id;
   assign wb_res_o   = r_wb_res;
   assign timeout_o  = w_abort;
   assign id_err_o   = w_capture & (div_id_i != r_exp_id);
   assign busy_o     = (r_state != IDLE) | ~w_empty;

   // Flush outranks every handshake and the watchdog.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= IDLE;
         r_timer  <= '0;
         r_exp_id <= '0;
         r_wb_id  <= '0;
         r_wb_res <= '0;
      end else if (flush_i) begin
         r_state <= IDLE;
         r_timer <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (!w_empty) r_state <= ISSUE;
            end
            ISSUE: begin
               if (div_in_rdy_i) begin
                  r_exp_id <= w_head.id;
                  r_timer  <= '0;
                  r_state  <= WAIT;
               end
            end
            WAIT: begin
               if (div_out_vld_i) begin
                  r_wb_id  <= div_id_i;
                  r_wb_res <= div_res_i;
                  r_state  <= RESP;
               end else if (r_timer == TLAST) begin
                  r_timer <= '0;
                  r_state <= IDLE;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            RESP: begin
               if (wb_ready_i) r_state <= w_empty ? IDLE : ISSUE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
